// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types, reset constant and instruction field decoder for the fetch front end
package fetch_unit_pkg;
  typedef logic [31:0] Vec32;
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    Vec32        instructionCode;
  } Instruction;
  typedef struct packed {
    Vec32 pc;
    Vec32 word;
  } FetchEntry;
  localparam Vec32 RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic Instruction decode_fields(input Vec32 w);
    return '{rs: w[25:21], rt: w[20:16], rd: w[15:11], shamt: w[10:6], funct: w[5:0],
             imm16: w[15:0], imm26: w[25:0], instructionCode: w};
  endfunction
endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular FIFO of fetch entries; flush empties it while still honouring a same-cycle pop
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  FetchEntry push_data,
  output logic      full,
  output logic      empty,
  output FetchEntry head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  FetchEntry mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign head_data = mem_q[head_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && !flush && (!full || do_pop);
    head_d = flush ? tail_q : head_q + AW'(do_pop);
    tail_d = tail_q + AW'(do_push);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[tail_q] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: drives fetch addresses, queues returned words and presents decoded instructions to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter Vec32 RESET_PC = RESET_PC_DEFAULT,
  parameter int   DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_address,
  input  logic [31:0] im_word,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output Instruction  if_instruction
);
  Vec32 fetch_pc_q, fetch_pc_d;
  logic push, pop, full, empty;
  FetchEntry push_entry, head;
  always_comb begin
    pop = !empty && if_ready;
    push = !redirect_valid && (!full || pop);
    push_entry = '{pc: fetch_pc_q, word: im_word};
    fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
  end
  always_ff @(posedge clk) fetch_pc_q <= !rst_n ? {RESET_PC[31:2], 2'b00} : fetch_pc_d;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );
  assign im_address = fetch_pc_q;
  assign if_valid = !empty;
  assign if_pc = head.pc;
  assign if_instruction = decode_fields(head.word);
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Drives word addresses into InstructionMemory and captures the returned words into a small prefetch queue.
- Presents {pc, decoded Instruction} to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump/exception), which flush the queue and restart fetch.
- Sits between InstructionMemory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- im_address  output  32 (Vec32)  fetch address to InstructionMemory.
- im_word  input  32 (Vec32)  instruction word returned combinationally, same cycle, for im_address.
- redirect_valid  input  1  redirect request from execute.
- redirect_pc  input  32 (Vec32)  new fetch target.
- if_valid  output  1  queue head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_pc  output  32 (Vec32)  PC of the head entry.
- if_instruction  output  Instruction  head word with fields sliced: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm16[15:0], imm26[25:0], instructionCode = full word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset, rst_n=0 at a clock edge:
  - fetch_pc <= RESET_PC.
  - Queue emptied: head=tail=0, count=0.
  - if_valid=0 from the following cycle.
  - im_address = RESET_PC.
  - Reset asserted mid-operation discards all queued entries and any redirect presented in the same cycle.
- Address path:
  - im_address = fetch_pc at all times (registered, glitch-free).
  - fetch_pc always has bits [1:0] = 0.
- Push:
  - Condition: redirect_valid=0 AND (count<DEPTH OR pop this cycle).
  - Action: enqueue {fetch_pc, im_word}; fetch_pc <= fetch_pc+4.
  - fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Pop:
  - Condition: if_valid && if_ready.
  - Action: head advances and the entry is consumed.
- Outputs: if_valid = (count!=0). if_pc and if_instruction are taken combinationally from the head entry and hold stable while if_valid && !if_ready.
- Full queue: push and pop in the same cycle is allowed, and count is unchanged. With no pop, fetch_pc holds and no entry is written.
- Empty queue: if_ready is ignored. Throughput is 1 instr/cycle steady-state, so the first instruction is visible 1 cycle after push.
- Redirect (redirect_valid=1):
  - A pop in the same cycle completes, since decode consumed the head (e.g. the branch itself).
  - Then every remaining entry is discarded: count <= 0, head=tail.
  - No push that cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - if_valid=0 the next cycle.
  - The first target instruction is visible 2 cycles after redirect (pushed on cycle +1, presented on cycle +2).
- Back-to-back redirects: the last one wins. Each flushes again.
- Reset has priority over redirect; redirect has priority over push.
- count is $clog2(DEPTH)+1 bits wide. head and tail are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package / common.vh:
  - Vec32 and Instruction (existing).
  - New FetchEntry struct {Vec32 pc; Vec32 word}.
  - Constant RESET_PC_DEFAULT.
  - Function decode_fields(Vec32) -> Instruction, so the field slicing is defined once.
- One natural sub-module: fetch_queue, a parameterised circular FIFO of FetchEntry.
  - Ports: push, pop, flush, full, empty, head data.
  - Flush clears the queue; an accepted pop still completes in the flush cycle.
- fetch_unit holds fetch_pc, push/redirect control and output decoding.

Test Plan:
- Reset then if_ready=1 held, memory words = index: if_pc sequence 0,4,8,12 on consecutive cycles from the cycle after the first push; if_instruction.instructionCode = 0,1,2,3.
- if_ready=0 for 10 cycles after reset: count saturates at 4; im_address holds 32'h10; if_pc stays 0. Raise if_ready: pc 0,4,8,C,10 with no gap.
- Redirect to 32'h0000_0200 while queue holds 0..C and if_ready=1: the head (pc 0) is consumed; if_valid=0 next cycle; next delivered pc = 32'h200; pcs 4..C never appear.
- redirect_pc=32'h0000_0103: fetch resumes at 32'h100.
- Word 32'h0211_8820 at pc 0: rs=16, rt=17, rd=17, shamt=0, funct=6'h20, imm16=16'h8820.
- rst_n=0 for one cycle with a full queue and redirect_valid=1: the redirect is ignored; if_valid=0 next cycle; im_address=RESET_PC; the PC stream restarts at RESET_PC.
